hr_tx_word_sched: RTL and testbench
===================================

Name: hr_tx_word_sched

Overview:
- Word-level scheduler that generates the 16-bit parallel word for the half-rate 16:4 serializer mux.
- Runs in the divided word-clock domain (clk_prbs) produced alongside the mux.
- Sequences the link: OFF, then a training burst, then RUN.
- In RUN, selects the per-word source: buffered user data, PRBS word, or idle fill. A small FIFO with a valid/ready handshake decouples the user source.

Parameters:
- FIFO_DEPTH, 4: user-data FIFO entries (power of 2, ≥2).
- TRAIN_LEN, 64: words emitted per training burst (≥2).
- TRAIN_PAT, 16'hAAAA: training word; each 4-bit lane sees a 1010 clock-like pattern.
- IDLE_PAT, 16'h0F0F: fill word used on underflow, idle mode and reserved mode.

Ports:
- clk_prbs, in, 1: word clock (half-rate clock divided by 2). All logic is on its rising edge.
- rstb, in, 1: asynchronous active-low reset.
- en, in, 1: link enable. Low forces OFF.
- train_req, in, 1: single-cycle request to (re)start training.
- mode, in, 2: RUN source select. 0 = user FIFO, 1 = PRBS, 2 = idle, 3 = reserved (treated as idle).
- prbs_word, in, 16: PRBS generator word, sampled every cycle.
- user_data, in, 16: user word.
- user_valid, in, 1: user word present.
- user_ready, out, 1: FIFO can accept a word.
- din, out, 16: registered word to the 16:4 mux data input.
- state, out, 2: 0 = OFF, 1 = TRAIN, 2 = RUN.
- train_done, out, 1: one-cycle pulse when a training burst completes.
- underflow, out, 1: one-cycle pulse when a user word was needed and the FIFO was empty.
- fifo_level, out, clog2(FIFO_DEPTH)+1: current FIFO occupancy.

Behaviour:
- Reset (rstb low, asynchronous):
  - din = 0, state = OFF, train_done = 0, underflow = 0.
  - FIFO emptied, fifo_level = 0, training counter = 0, user_ready = 0.
- Reset release is synchronous to clk_prbs. Outputs update only on clk_prbs edges.
- All outputs are registered except user_ready, which is combinational: user_ready = en && (fifo_level < FIFO_DEPTH).
- Push happens when user_valid && user_ready at a clock edge. Push is allowed in TRAIN and RUN, so the FIFO can prefill during training.
- FSM transitions:
  - OFF → TRAIN when en = 1. Counter cleared. din = 0 while in OFF.
  - TRAIN: din = TRAIN_PAT every cycle, counter increments.
    - On the cycle the counter reaches TRAIN_LEN-1: next state is RUN, train_done pulses in the first RUN cycle, counter clears.
    - Exactly TRAIN_LEN TRAIN_PAT words are emitted.
  - TRAIN with train_req = 1: counter restarts at 0. That cycle's word is still TRAIN_PAT, and the burst is TRAIN_LEN words from the restart.
  - RUN with train_req = 1: next state is TRAIN. The current cycle's word is produced per mode; TRAIN_PAT starts on the next word.
  - Any state with en = 0: next state is OFF, FIFO flushed, counter cleared.
    - en = 0 has priority over train_req.
    - din = 0 from the next edge.
- RUN word selection (registered, latency 1; the word chosen at edge N appears on din after edge N):
  - mode 0, FIFO non-empty: pop the head word and drive it on din.
  - mode 0, FIFO empty: din = IDLE_PAT, underflow pulses, no pop.
  - mode 1: din = prbs_word sampled at that edge. No pop.
  - mode 2 or 3: din = IDLE_PAT. No pop.
  - A mode change applies at the next edge; no word is lost or duplicated.
- FIFO rules:
  - Circular buffer with wrap-around pointers. Ordering is strictly FIFO.
  - Simultaneous push and pop: level unchanged, and both take effect.
  - Push into an empty FIFO and pop in the same cycle: the pop sees the FIFO as empty, so underflow pulses and the pushed word is kept.
  - Full FIFO: user_ready = 0, and user_data is ignored.
- Reset asserted mid-burst or mid-RUN: immediate return to reset values; no partial state survives.

Test Plan:
- Reset then en = 1 with TRAIN_LEN = 8 → din = 0 in OFF, then 8 words of 0xAAAA, state 1→2, train_done high for exactly 1 cycle, then din = 0x0F0F with mode = 2.
- mode 0, push 0x1111, 0x2222, 0x3333, 0x4444 during TRAIN (FIFO_DEPTH = 4) → user_ready = 0 at level 4; in RUN din = 0x1111, 0x2222, 0x3333, 0x4444 in order; next word is 0x0F0F with an underflow pulse.
- mode 0 steady state, user pushes 1 word/cycle starting at RUN → after the first underflow, each word appears on din one cycle after push; level stays ≤1 with simultaneous push/pop; 20 consecutive words delivered without loss.
- mode 1 with prbs_word = 0xBEEF, then 0x1234 → din shows each value one cycle later; mode switched to 0 mid-stream → the first FIFO word follows the last PRBS word directly.
- train_req in RUN at word 5, and again mid-TRAIN at count 3 → TRAIN restarts; exactly 8 0xAAAA words after the last request; train_done pulses once.
- en = 0 with 2 words in FIFO during RUN → state = 0, din = 0, fifo_level = 0 next cycle. Separately, rstb low mid-TRAIN → immediate reset values without a clock edge.

Source files
------------

// File: rtl/hr_tx_word_sched.sv
// hr_tx_word_sched: builds the 16-bit parallel word for the half-rate 16:4
// serializer mux. Sequences OFF -> TRAIN -> RUN and, in RUN, picks the word
// source (user FIFO, PRBS or idle fill) one word clock ahead of the mux.
//
// state | meaning
// ------+-------------------------------------------------------------
// OFF   | link disabled, din held at zero, FIFO kept empty
// TRAIN | emitting TRAIN_PAT, counter tracks position inside the burst
// RUN   | per-word source chosen by mode; train_req returns to TRAIN
//
// din is chosen from the state being entered, so the word on din always
// belongs to the state shown on the state output.
module hr_tx_word_sched #(
  parameter int          FIFO_DEPTH = 4,
  parameter int          TRAIN_LEN  = 64,
  parameter logic [15:0] TRAIN_PAT  = 16'hAAAA,
  parameter logic [15:0] IDLE_PAT   = 16'h0F0F
) (
  input  logic                          clk_prbs,
  input  logic                          rstb,
  input  logic                          en,
  input  logic                          train_req,
  input  logic [1:0]                    mode,
  input  logic [15:0]                   prbs_word,
  input  logic [15:0]                   user_data,
  input  logic                          user_valid,
  output logic                          user_ready,
  output logic [15:0]                   din,
  output logic [1:0]                    state,
  output logic                          train_done,
  output logic                          underflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(TRAIN_LEN);

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_TRAIN = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  state_t          cur_state;
  state_t          nxt_state;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_nxt;
  logic            burst_end;

  logic [15:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            fifo_empty;
  logic            push;
  logic            pop;
  logic            starve;
  logic [15:0]     din_nxt;

  assign state      = cur_state;
  assign fifo_empty = (fifo_level == '0);

  // Ready is gated by reset so nothing can be accepted while the block is held.
  assign user_ready = rstb && en && (fifo_level < LW'(FIFO_DEPTH));
  assign push       = user_valid && user_ready;

  // State register.
  always_ff @(posedge clk_prbs or negedge rstb) begin
    if (!rstb) begin
      cur_state <= ST_OFF;
    end else begin
      cur_state <= nxt_state;
    end
  end

  // Next-state decode; en low wins over everything including train_req.
  always_comb begin
    nxt_state = cur_state;
    burst_end = 1'b0;
    case (cur_state)
      ST_OFF: begin
        nxt_state = ST_TRAIN;
      end
      ST_TRAIN: begin
        if (!train_req && (cnt == CW'(TRAIN_LEN - 1))) begin
          nxt_state = ST_RUN;
          burst_end = 1'b1;
        end
      end
      ST_RUN: begin
        if (train_req) begin
          nxt_state = ST_TRAIN;
        end
      end
      default: begin
        nxt_state = ST_OFF;
      end
    endcase
    if (!en) begin
      nxt_state = ST_OFF;
      burst_end = 1'b0;
    end
  end

  // Burst counter only advances while staying in TRAIN without a restart.
  always_comb begin
    cnt_nxt = '0;
    if ((cur_state == ST_TRAIN) && (nxt_state == ST_TRAIN) && !train_req) begin
      cnt_nxt = cnt + CW'(1);
    end
  end

  // Word select for the state being entered; a pop only happens on a RUN word.
  always_comb begin
    din_nxt = '0;
    pop     = 1'b0;
    starve  = 1'b0;
    case (nxt_state)
      ST_TRAIN: begin
        din_nxt = TRAIN_PAT;
      end
      ST_RUN: begin
        case (mode)
          2'd0: begin
            if (fifo_empty) begin
              din_nxt = IDLE_PAT;
              starve  = 1'b1;
            end else begin
              din_nxt = mem[rd_ptr];
              pop     = 1'b1;
            end
          end
          2'd1: begin
            din_nxt = prbs_word;
          end
          default: begin
            din_nxt = IDLE_PAT;
          end
        endcase
      end
      default: begin
        din_nxt = '0;
      end
    endcase
  end

  // Registered word, burst counter and status pulses.
  always_ff @(posedge clk_prbs or negedge rstb) begin
    if (!rstb) begin
      din        <= '0;
      cnt        <= '0;
      train_done <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      din        <= din_nxt;
      cnt        <= cnt_nxt;
      train_done <= burst_end;
      underflow  <= starve;
    end
  end

  // FIFO pointers and occupancy; en low flushes. Pop decisions use the
  // pre-edge level, so a push into an empty FIFO is never popped the same cycle.
  always_ff @(posedge clk_prbs or negedge rstb) begin
    if (!rstb) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else if (!en) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LW'(1);
        2'b01:   fifo_level <= fifo_level - LW'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // FIFO storage; contents are unreachable after a flush because level is zero.
  always_ff @(posedge clk_prbs) begin
    if (push) begin
      mem[wr_ptr] <= user_data;
    end
  end

endmodule

// File: tb/tb_hr_tx_word_sched.sv
// Bench for hr_tx_word_sched: a directed vector table, hand sequences for
// steady streaming, training restarts and async reset, then random traffic
// checked against a queue-based reference model.
module tb_hr_tx_word_sched;

  localparam int          DEPTH = 4;
  localparam int          TLEN  = 8;
  localparam logic [15:0] TPAT  = 16'hAAAA;
  localparam logic [15:0] IPAT  = 16'h0F0F;

  logic        clk_prbs = 1'b0;
  logic        rstb;
  logic        en;
  logic        train_req;
  logic [1:0]  mode;
  logic [15:0] prbs_word;
  logic [15:0] user_data;
  logic        user_valid;
  logic        user_ready;
  logic [15:0] din;
  logic [1:0]  state;
  logic        train_done;
  logic        underflow;
  logic [2:0]  fifo_level;

  int total = 0;
  int bad   = 0;

  hr_tx_word_sched #(
    .FIFO_DEPTH (DEPTH),
    .TRAIN_LEN  (TLEN),
    .TRAIN_PAT  (TPAT),
    .IDLE_PAT   (IPAT)
  ) dut (
    .clk_prbs   (clk_prbs),
    .rstb       (rstb),
    .en         (en),
    .train_req  (train_req),
    .mode       (mode),
    .prbs_word  (prbs_word),
    .user_data  (user_data),
    .user_valid (user_valid),
    .user_ready (user_ready),
    .din        (din),
    .state      (state),
    .train_done (train_done),
    .underflow  (underflow),
    .fifo_level (fifo_level)
  );

  always #5 clk_prbs = ~clk_prbs;

  // Reference model: link phase, words left in the current burst, FIFO queue.
  int          m_state;
  int          m_left;
  logic [15:0] m_q[$];
  logic [15:0] m_din;
  logic        m_td;
  logic        m_uf;

  typedef struct {
    logic        en;
    logic        req;
    logic [1:0]  mode;
    logic [15:0] prbs;
    logic [15:0] data;
    logic        valid;
    logic [15:0] e_din;
    logic [1:0]  e_state;
    logic        e_td;
    logic        e_uf;
    logic [2:0]  e_lvl;
    logic        e_rdy;
  } vec_t;

  vec_t tbl[21];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    m_left  = 0;
    m_q.delete();
    m_din   = 16'h0;
    m_td    = 1'b0;
    m_uf    = 1'b0;
  endtask

  task automatic model_run_word(input logic [1:0] md, input logic [15:0] pw);
    if (md == 2'd1) begin
      m_din = pw;
    end else if (md == 2'd0) begin
      if (m_q.size() == 0) begin
        m_din = IPAT;
        m_uf  = 1'b1;
      end else begin
        m_din = m_q.pop_front();
      end
    end else begin
      m_din = IPAT;
    end
  endtask

  task automatic model_edge(input logic i_en, input logic i_req, input logic [1:0] i_mode,
                            input logic [15:0] i_prbs, input logic [15:0] i_data,
                            input logic i_valid);
    bit push_ok;
    push_ok = i_valid && i_en && (m_q.size() < DEPTH);
    m_td = 1'b0;
    m_uf = 1'b0;
    if (!i_en) begin
      m_state = 0;
      m_left  = 0;
      m_din   = 16'h0;
      m_q.delete();
    end else begin
      case (m_state)
        0: begin
          m_state = 1;
          m_left  = TLEN;
          m_din   = TPAT;
        end
        1: begin
          if (i_req) begin
            m_left = TLEN;
            m_din  = TPAT;
          end else begin
            m_left--;
            if (m_left == 0) begin
              m_state = 2;
              m_td    = 1'b1;
              model_run_word(i_mode, i_prbs);
            end else begin
              m_din = TPAT;
            end
          end
        end
        default: begin
          if (i_req) begin
            m_state = 1;
            m_left  = TLEN;
            m_din   = TPAT;
          end else begin
            model_run_word(i_mode, i_prbs);
          end
        end
      endcase
      if (push_ok) m_q.push_back(i_data);
    end
  endtask

  task automatic drive_edge(input logic i_en, input logic i_req, input logic [1:0] i_mode,
                            input logic [15:0] i_prbs, input logic [15:0] i_data,
                            input logic i_valid);
    en         = i_en;
    train_req  = i_req;
    mode       = i_mode;
    prbs_word  = i_prbs;
    user_data  = i_data;
    user_valid = i_valid;
    @(posedge clk_prbs);
    #1;
  endtask

  task automatic step(input logic i_en, input logic i_req, input logic [1:0] i_mode,
                      input logic [15:0] i_prbs, input logic [15:0] i_data,
                      input logic i_valid);
    drive_edge(i_en, i_req, i_mode, i_prbs, i_data, i_valid);
    model_edge(i_en, i_req, i_mode, i_prbs, i_data, i_valid);
    chk("m_din", din, m_din);
    chk("m_state", state, m_state);
    chk("m_train_done", train_done, m_td);
    chk("m_underflow", underflow, m_uf);
    chk("m_level", fifo_level, m_q.size());
    chk("m_ready", user_ready, en && (m_q.size() < DEPTH));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_din"}, din, 16'h0);
    chk({tag, "_state"}, state, 2'd0);
    chk({tag, "_train_done"}, train_done, 1'b0);
    chk({tag, "_underflow"}, underflow, 1'b0);
    chk({tag, "_level"}, fifo_level, 3'd0);
    chk({tag, "_ready"}, user_ready, 1'b0);
  endtask

  task automatic do_reset();
    rstb       = 1'b0;
    en         = 1'b0;
    train_req  = 1'b0;
    mode       = 2'd0;
    prbs_word  = 16'h0;
    user_data  = 16'h0;
    user_valid = 1'b0;
    repeat (2) @(posedge clk_prbs);
    #3;
    chk_reset_vals("rst");
    rstb = 1'b1;
    model_reset();
  endtask

  // Guard against a hung run.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          n_aa;
    int          n_td;
    int          guard;
    logic [15:0] prev;
    logic [15:0] w;

    // en, req, mode, prbs, data, valid | din, state, td, uf, level, ready
    tbl[0]  = '{1'b1, 1'b0, 2'd0, 16'h0000, 16'h0000, 1'b0, TPAT,     2'd1, 1'b0, 1'b0, 3'd0, 1'b1};
    tbl[1]  = '{1'b1, 1'b0, 2'd0, 16'h0000, 16'h1111, 1'b1, TPAT,     2'd1, 1'b0, 1'b0, 3'd1, 1'b1};
    tbl[2]  = '{1'b1, 1'b0, 2'd0, 16'h0000, 16'h2222, 1'b1, TPAT,     2'd1, 1'b0, 1'b0, 3'd2, 1'b1};
    tbl[3]  = '{1'b1, 1'b0, 2'd0, 16'h0000, 16'h3333, 1'b1, TPAT,     2'd1, 1'b0, 1'b0, 3'd3, 1'b1};
    tbl[4]  = '{1'b1, 1'b0, 2'd0, 16'h0000, 16'h4444, 1'b1, TPAT,     2'd1, 1'b0, 1'b0, 3'd4, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 2'd0, 16'h0000, 16'h5555, 1'b1, TPAT,     2'd1, 1'b0, 1'b0, 3'd4, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 2'd0, 16'h0000, 16'h0000, 1'b0, TPAT,     2'd1, 1'b0, 1'b0, 3'd4, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 2'd0, 16'h0000, 16'h0000, 1'b0, TPAT,     2'd1, 1'b0, 1'b0, 3'd4, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 2'd0, 16'h0000, 16'h0000, 1'b0, 16'h1111, 2'd2, 1'b1, 1'b0, 3'd3, 1'b1};
    tbl[9]  = '{1'b1, 1'b0, 2'd0, 16'h0000, 16'h0000, 1'b0, 16'h2222, 2'd2, 1'b0, 1'b0, 3'd2, 1'b1};
    tbl[10] = '{1'b1, 1'b0, 2'd0, 16'h0000, 16'h0000, 1'b0, 16'h3333, 2'd2, 1'b0, 1'b0, 3'd1, 1'b1};
    tbl[11] = '{1'b1, 1'b0, 2'd0, 16'h0000, 16'h0000, 1'b0, 16'h4444, 2'd2, 1'b0, 1'b0, 3'd0, 1'b1};
    tbl[12] = '{1'b1, 1'b0, 2'd0, 16'h0000, 16'h0000, 1'b0, IPAT,     2'd2, 1'b0, 1'b1, 3'd0, 1'b1};
    tbl[13] = '{1'b1, 1'b0, 2'd2, 16'h0000, 16'h0000, 1'b0, IPAT,     2'd2, 1'b0, 1'b0, 3'd0, 1'b1};
    tbl[14] = '{1'b1, 1'b0, 2'd1, 16'hBEEF, 16'h0000, 1'b0, 16'hBEEF, 2'd2, 1'b0, 1'b0, 3'd0, 1'b1};
    tbl[15] = '{1'b1, 1'b0, 2'd1, 16'h1234, 16'h7777, 1'b1, 16'h1234, 2'd2, 1'b0, 1'b0, 3'd1, 1'b1};
    tbl[16] = '{1'b1, 1'b0, 2'd0, 16'h0000, 16'h0000, 1'b0, 16'h7777, 2'd2, 1'b0, 1'b0, 3'd0, 1'b1};
    tbl[17] = '{1'b1, 1'b0, 2'd3, 16'h0000, 16'h8888, 1'b1, IPAT,     2'd2, 1'b0, 1'b0, 3'd1, 1'b1};
    tbl[18] = '{1'b1, 1'b0, 2'd2, 16'h0000, 16'h9999, 1'b1, IPAT,     2'd2, 1'b0, 1'b0, 3'd2, 1'b1};
    tbl[19] = '{1'b0, 1'b1, 2'd0, 16'h0000, 16'hCAFE, 1'b1, 16'h0000, 2'd0, 1'b0, 1'b0, 3'd0, 1'b0};
    tbl[20] = '{1'b0, 1'b0, 2'd0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 2'd0, 1'b0, 1'b0, 3'd0, 1'b0};

    do_reset();
    for (int i = 0; i < 21; i++) begin
      drive_edge(tbl[i].en, tbl[i].req, tbl[i].mode, tbl[i].prbs, tbl[i].data, tbl[i].valid);
      chk($sformatf("v%0d_din", i), din, tbl[i].e_din);
      chk($sformatf("v%0d_state", i), state, tbl[i].e_state);
      chk($sformatf("v%0d_train_done", i), train_done, tbl[i].e_td);
      chk($sformatf("v%0d_underflow", i), underflow, tbl[i].e_uf);
      chk($sformatf("v%0d_level", i), fifo_level, tbl[i].e_lvl);
      chk($sformatf("v%0d_ready", i), user_ready, tbl[i].e_rdy);
    end

    // Steady streaming: one push per cycle from the first RUN word onward.
    do_reset();
    for (int i = 0; i < TLEN; i++) step(1'b1, 1'b0, 2'd0, 16'h0, 16'h0, 1'b0);
    prev = 16'h0;
    for (int i = 0; i <= 20; i++) begin
      w = 16'h5000 + 16'(i);
      step(1'b1, 1'b0, 2'd0, 16'h0, w, 1'b1);
      if (i == 0) begin
        chk("ss_first_underflow", underflow, 1'b1);
      end else begin
        chk("ss_din", din, prev);
        chk("ss_level_le1", fifo_level <= 3'd1, 1'b1);
      end
      prev = w;
    end

    // Training restarts: request at RUN word 5, again at TRAIN count 3.
    do_reset();
    for (int i = 0; i < TLEN + 1; i++) step(1'b1, 1'b0, 2'd2, 16'h0, 16'h0, 1'b0);
    chk("tr_in_run", state, 2'd2);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 2'd2, 16'h0, 16'h0, 1'b0);
    n_td = 0;
    step(1'b1, 1'b1, 2'd2, 16'h0, 16'h0, 1'b0);
    chk("tr_req_run_state", state, 2'd1);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 2'd2, 16'h0, 16'h0, 1'b0);
      if (train_done) n_td++;
    end
    step(1'b1, 1'b1, 2'd2, 16'h0, 16'h0, 1'b0);
    if (train_done) n_td++;
    n_aa  = (state == 2'd1 && din == TPAT) ? 1 : 0;
    guard = 0;
    while (state == 2'd1 && guard < 30) begin
      step(1'b1, 1'b0, 2'd2, 16'h0, 16'h0, 1'b0);
      if (train_done) n_td++;
      if (state == 2'd1 && din == TPAT) n_aa++;
      guard++;
    end
    chk("tr_bounded", guard < 30, 1'b1);
    chk("tr_words_after_req", n_aa, TLEN);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 2'd2, 16'h0, 16'h0, 1'b0);
      if (train_done) n_td++;
    end
    chk("tr_done_pulses", n_td, 1);

    // Async reset mid-burst with a partially filled FIFO, no clock edge needed.
    do_reset();
    step(1'b1, 1'b0, 2'd0, 16'h0, 16'h0, 1'b0);
    step(1'b1, 1'b0, 2'd0, 16'h0, 16'hD00D, 1'b1);
    step(1'b1, 1'b0, 2'd0, 16'h0, 16'hF00D, 1'b1);
    chk("ar_pre_level", fifo_level, 3'd2);
    rstb = 1'b0;
    #1;
    chk_reset_vals("ar");
    #1;
    rstb = 1'b1;
    model_reset();

    // Random traffic against the reference model.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 24) != 0),
           ($urandom_range(0, 29) == 0),
           2'($urandom_range(0, 3)),
           16'($urandom),
           16'($urandom),
           ($urandom_range(0, 1) == 1));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
